// File: rtl/ser_mult3_tx_pkg.sv
// Shared constants and FSM encoding for the serial times-three transmitter.
package ser_mult3_tx_pkg;

  localparam int W_DEFAULT = 8;
  localparam int FRAME_LEN = W_DEFAULT + 2;
  localparam int CNT_W     = $clog2(FRAME_LEN);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

endpackage

// File: rtl/ser_mult3_tx.sv
// Serial transmitter for y = 3*x, one bit per clock, LSB first, W+2 bits per frame.
// The product is built on the fly as x + (x<<1) with a one-bit carry.
module ser_mult3_tx
  import ser_mult3_tx_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] data_in,
  output logic         ready,
  output logic         bit_out,
  output logic         bit_valid,
  output logic         last
);

  localparam int            CntW    = $clog2(W + 2);
  localparam logic [CntW-1:0] LastIdx = CntW'(W + 1);

  state_e          state_q, state_d;
  logic [W-1:0]    xShift_q, xShift_d;
  logic            prevBit_q, prevBit_d;
  logic            carry_q, carry_d;
  logic [CntW-1:0] bitCnt_q, bitCnt_d;
  logic            bitOut_q, bitOut_d;

  logic lastCycle;
  logic accept;

  assign lastCycle = (state_q == SEND) && (bitCnt_q == LastIdx);
  assign accept    = load && ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SEND;
      SEND:    if (lastCycle && !accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready     = 1'b1;
    bit_valid = 1'b0;
    last      = 1'b0;
    if (state_q == SEND) begin
      bit_valid = 1'b1;
      last      = lastCycle;
      ready     = lastCycle;
    end
  end

  assign bit_out = bitOut_q;

  // Bit 0 has no lower neighbour and no carry-in, so y[0] is just x[0].
  always_comb begin
    xShift_d  = xShift_q;
    prevBit_d = prevBit_q;
    carry_d   = carry_q;
    bitCnt_d  = bitCnt_q;
    bitOut_d  = bitOut_q;
    if (accept) begin
      xShift_d  = data_in >> 1;
      prevBit_d = data_in[0];
      carry_d   = 1'b0;
      bitCnt_d  = '0;
      bitOut_d  = data_in[0];
    end else if (state_q == SEND && !lastCycle) begin
      xShift_d  = xShift_q >> 1;
      prevBit_d = xShift_q[0];
      bitOut_d  = xShift_q[0] ^ prevBit_q ^ carry_q;
      carry_d   = (xShift_q[0] & prevBit_q) | (xShift_q[0] & carry_q) | (prevBit_q & carry_q);
      bitCnt_d  = bitCnt_q + CntW'(1);
    end else if (lastCycle) begin
      prevBit_d = 1'b0;
      carry_d   = 1'b0;
      bitCnt_d  = '0;
      bitOut_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      xShift_q  <= '0;
      prevBit_q <= 1'b0;
      carry_q   <= 1'b0;
      bitCnt_q  <= '0;
      bitOut_q  <= 1'b0;
    end else begin
      xShift_q  <= xShift_d;
      prevBit_q <= prevBit_d;
      carry_q   <= carry_d;
      bitCnt_q  <= bitCnt_d;
      bitOut_q  <= bitOut_d;
    end
  end

endmodule

// File: tb/tb_ser_mult3_tx.sv
// Self-checking bench for ser_mult3_tx (W=8): vector table, corner sequences,
// exhaustive operand sweep and a randomized run against a frame-level model.
module tb_ser_mult3_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [7:0] data_in;
  logic       ready;
  logic       bit_out;
  logic       bit_valid;
  logic       last;

  int compared = 0;
  int failed   = 0;

  typedef struct {
    logic [7:0] x;
    logic [9:0] y;
  } vec_t;

  vec_t vecs[7];

  ser_mult3_tx #(.W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .data_in   (data_in),
    .ready     (ready),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .last      (last)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Flags are packed as {bit_valid, ready, bit_out, last}; idle is 4'b0100.
  task automatic checkIdle(input string name);
    @(negedge clk);
    checkOutput(name, 32'({bit_valid, ready, bit_out, last}), 32'(4'b0100));
  endtask

  // Starts just after a negedge with the DUT ready; ends at the negedge showing bit 9.
  task automatic applyStimulus(input logic [7:0] x, output logic [9:0] bits,
                               output logic [9:0] validMask, output logic [9:0] lastMask,
                               output logic [9:0] readyMask);
    load    = 1'b1;
    data_in = x;
    @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) load = 1'b0;
      bits[i]      = bit_out;
      validMask[i] = bit_valid;
      lastMask[i]  = last;
      readyMask[i] = ready;
    end
  endtask

  initial begin
    logic [9:0]  bits, vm, lm, rm;
    logic [19:0] bits20, vm20, lm20;
    logic [3:0]  expV;
    int          pos;
    logic [9:0]  frm;

    vecs[0] = '{x: 8'd5,   y: 10'd15};
    vecs[1] = '{x: 8'd255, y: 10'd765};
    vecs[2] = '{x: 8'd0,   y: 10'd0};
    vecs[3] = '{x: 8'd85,  y: 10'd255};
    vecs[4] = '{x: 8'd1,   y: 10'd3};
    vecs[5] = '{x: 8'd170, y: 10'd510};
    vecs[6] = '{x: 8'd128, y: 10'd384};

    // Reset held with load asserted: load must be overridden.
    rst = 1'b0; load = 1'b1; data_in = 8'hAA;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset idle", 32'({bit_valid, ready, bit_out, last}), 32'(4'b0100));
    rst = 1'b1; load = 1'b0;
    checkIdle("post reset no frame");

    for (int v = 0; v < 7; v++) begin
      applyStimulus(vecs[v].x, bits, vm, lm, rm);
      checkOutput($sformatf("table frame x=%0d", vecs[v].x), 32'(bits), 32'(vecs[v].y));
      checkOutput($sformatf("table valid x=%0d", vecs[v].x), 32'(vm), 32'(10'h3FF));
      checkOutput($sformatf("table last x=%0d", vecs[v].x), 32'(lm), 32'(10'h200));
      checkOutput($sformatf("table ready x=%0d", vecs[v].x), 32'(rm), 32'(10'h200));
      checkIdle($sformatf("table idle after x=%0d", vecs[v].x));
    end

    // Back-to-back: 85 then 5 loaded in the last cycle of the first frame.
    load = 1'b1; data_in = 8'd85;
    @(posedge clk);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      bits20[c] = bit_out;
      vm20[c]   = bit_valid;
      lm20[c]   = last;
      load      = (c == 9);
      if (c == 9) data_in = 8'd5;
    end
    checkOutput("b2b bits", 32'(bits20), 32'({10'd15, 10'd255}));
    checkOutput("b2b valid", 32'(vm20), 32'(20'hFFFFF));
    checkOutput("b2b last", 32'(lm20), 32'(20'h80200));
    checkIdle("b2b idle");

    // Ignored load during a frame plus data_in churn after acceptance.
    load = 1'b1; data_in = 8'd5;
    @(posedge clk);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      bits[c] = bit_out;
      load    = (c == 2);
      data_in = (c == 2) ? 8'd7 : (c >= 4 ? 8'hFF : data_in);
    end
    data_in = 8'h00;
    checkOutput("ignored load frame", 32'(bits), 32'(10'd15));
    checkIdle("ignored load idle 1");
    checkIdle("ignored load idle 2");

    // Reset after bit 3 of x=255, with a competing load during reset.
    load = 1'b1; data_in = 8'd255;
    @(posedge clk);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 0) load = 1'b0;
      bits[c] = bit_out;
    end
    checkOutput("abort first bits", 32'(bits[3:0]), 32'(4'b1101));
    rst = 1'b0; load = 1'b1; data_in = 8'd9;
    @(negedge clk);
    checkOutput("abort idle", 32'({bit_valid, ready, bit_out, last}), 32'(4'b0100));
    rst = 1'b1; load = 1'b0;
    checkIdle("abort stays idle");
    applyStimulus(8'd1, bits, vm, lm, rm);
    checkOutput("after abort x=1", 32'(bits), 32'(10'd3));
    checkIdle("after abort idle");

    // Every operand: reassembled frame must equal 3*x.
    for (int x = 0; x < 256; x++) begin
      applyStimulus(8'(x), bits, vm, lm, rm);
      checkOutput($sformatf("sweep x=%0d", x), 32'({bits, vm, lm}),
                  32'({10'(3 * x), 10'h3FF, 10'h200}));
    end
    checkIdle("sweep idle");

    // Random loads, data and occasional resets against a frame-position model.
    pos = -1;
    frm = '0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      expV = {pos >= 0, (pos < 0) || (pos == 9), (pos >= 0) ? frm[pos] : 1'b0, pos == 9};
      checkOutput($sformatf("rand c%0d", c), 32'({bit_valid, ready, bit_out, last}), 32'(expV));
      rst     = ($urandom_range(0, 39) != 0);
      load    = ($urandom_range(0, 3) == 0);
      data_in = 8'($urandom);
      if (!rst) pos = -1;
      else if ((pos < 0 || pos == 9) && load) begin
        frm = 10'(3 * int'(data_in));
        pos = 0;
      end else if (pos == 9) pos = -1;
      else if (pos >= 0) pos++;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule

// File: doc/ser_mult3_tx.md
SER_MULT3_TX -- requirements
Module: ser_mult3_tx

Interface
REQ-001 Parameter: W, 8, operand width in bits; W >= 2.
REQ-002 Port: clk  input  1  single clock; all state updates on posedge clk.
REQ-003 Port: rst  input  1  reset, synchronous, active-low (rst=0 sampled at posedge resets the block).
REQ-004 Port: load  input  1  request to transmit data_in; accepted only when ready=1.
REQ-005 Port: data_in  input  W  unsigned operand x; sampled only on an accepted load.
REQ-006 Port: ready  output  1  block can accept load this cycle.
REQ-007 Port: bit_out  output  1  current serial bit of y = 3*x, LSB first.
REQ-008 Port: bit_valid  output  1  bit_out carries a frame bit this cycle.
REQ-009 Port: last  output  1  bit_out is the final (MSB) bit of the frame.

Function
REQ-010 Frame: y = 3*x, exactly FRAME_LEN = W+2 bits, LSB first, zero-extended; no truncation for any x.
REQ-011 Arithmetic: serial y = x + (x<<1); step i computes bit = x[i] ^ x[i-1] ^ c and c' = majority(x[i], x[i-1], c), with x[-1]=x[W]=x[W+1]=0 and c initially 0; carry is 1 bit.
REQ-012 FSM states: IDLE (no frame) and SEND (frame in flight); no other states.
REQ-013 IDLE: ready=1, bit_valid=0, bit_out=0, last=0.
REQ-014 Accept: load=1 with ready=1 at edge t captures data_in, clears carry and bit counter, and enters SEND.
REQ-015 Latency: after edge t+i, bit_out=y[i] and bit_valid=1 for i = 0..W+1; one bit per clock, no gaps.
REQ-016 last=1 only in the cycle after edge t+W+1 (bit y[W+1]); otherwise 0.
REQ-017 ready=0 in SEND except in the last=1 cycle, when ready=1.
REQ-018 Back-to-back: load=1 in the last=1 cycle starts the next frame; its y[0] appears after the next edge with bit_valid held at 1.
REQ-019 End of frame without a new load: after edge t+W+2, return to IDLE with bit_valid=0 and bit_out=0.
REQ-020 Load while ready=0 is ignored; the frame in flight and data_in capture are unaffected.
REQ-021 data_in changes after acceptance do not alter the frame in flight.
REQ-022 bit_out, bit_valid, last and ready are driven from registers or the state register only, with no combinational path from load or data_in.

Reset
REQ-023 rst=0 at a posedge forces IDLE: ready=1, bit_valid=0, bit_out=0, last=0, carry=0, counter=0.
REQ-024 Reset during SEND aborts the frame; no further bits of it are emitted.
REQ-025 rst=0 overrides a simultaneous load; the first accepted load is the first with rst=1.

Structure
REQ-026 Shared package holds the default W, FRAME_LEN = W+2, the counter width clog2(W+2), and the IDLE/SEND state encoding.
REQ-027 Single module; no sub-module; serial-adder step implemented inline.

Verification (W=8)
REQ-028 x=5 loaded -> 10 valid bits 1,1,1,1,0,0,0,0,0,0 (y=15); last on the 10th bit; ready=0 on bits 1-9.
REQ-029 x=255 -> 1,0,1,1,1,1,1,1,0,1 (y=765, carry through the MSB bits); x=0 -> ten 0s with bit_valid=1.
REQ-030 Back-to-back: x=85 then x=5 loaded in the last=1 cycle -> 1,1,1,1,1,1,1,1,0,0 then 1,1,1,1,0,0,0,0,0,0 with 20 contiguous valid cycles.
REQ-031 Reset mid-frame: rst=0 after bit 3 of x=255 -> next cycle bit_valid=0, ready=1; new load x=1 -> 1,1,0,0,0,0,0,0,0,0.
REQ-032 Ignored load and data_in change: load=1 with x=7 during x=5 frame, and data_in toggled after acceptance -> x=5 stream unchanged; x=7 never sent.
REQ-033 Self-check: for all x in 0..255, reassembled frame equals 3*x and is divisible by 3.
